// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int DW_DEF           = 16;
  localparam int AW_DEF           = 16;
  localparam int LW_DEF           = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } st_t;

endpackage

// File: rtl/dma_burst_ctr.sv
// Burst bookkeeping: holds the captured base/length, counts beats and
// produces the wrapping beat address plus the last-beat flag.
module dma_burst_ctr #(
  parameter int AW = 16,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [AW-1:0] base_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [LW-1:0] beat_cnt_q, beat_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    beat_cnt_d = beat_cnt_q;
    base_d     = base_q;
    len_d      = len_q;
    if (load_i) begin
      beat_cnt_d = '0;
      base_d     = base_i;
      len_d      = len_i;
    end else if (adv_i) begin
      beat_cnt_d = beat_cnt_q + LW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      base_q     <= '0;
      len_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      base_q     <= base_d;
      len_q      <= len_d;
    end
  end

  // Address arithmetic is AW bits wide, so bursts wrap modulo 2^AW.
  assign addr_o = base_q + AW'(beat_cnt_q);
  assign last_o = (beat_cnt_q == len_q);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the pipeline MEM stage (priority,
// single-cycle) and a DMA master (committed bursts) with anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int LW           = LW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pl_req,
  input  logic          pl_we,
  input  logic [AW-1:0] pl_addr,
  input  logic [DW-1:0] pl_wdata,
  output logic [DW-1:0] pl_rdata,
  output logic          pl_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [LW-1:0] dma_len,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_beat,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  st_t           st_q;
  logic [SW-1:0] starve_cnt_q;
  logic          we_q;
  logic          in_burst;
  logic          grant;
  logic          last_beat;
  logic [AW-1:0] burst_addr;

  assign in_burst = (st_q == ST_BURST);
  assign grant    = !in_burst && dma_req && (!pl_req || (starve_cnt_q >= STARVE_MAX));

  dma_burst_ctr #(
    .AW (AW),
    .LW (LW)
  ) u_burst_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (grant),
    .adv_i  (in_burst),
    .base_i (dma_addr),
    .len_i  (dma_len),
    .addr_o (burst_addr),
    .last_o (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= ST_IDLE;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (grant) begin
            st_q         <= ST_BURST;
            starve_cnt_q <= '0;
            we_q         <= dma_we;
          end else if (!dma_req) begin
            starve_cnt_q <= '0;
          end else if (pl_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_q <= starve_cnt_q + SW'(1);
          end
        end
        ST_BURST: begin
          // Burst length is fixed at grant; dma_req is ignored until the last beat.
          if (last_beat) st_q <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign dma_gnt   = in_burst;
  assign dma_beat  = in_burst;
  assign dma_done  = in_burst && last_beat;
  assign pl_stall  = in_burst && pl_req;

  assign mem_addr  = in_burst ? burst_addr : pl_addr;
  assign mem_wdata = in_burst ? dma_wdata  : pl_wdata;
  // NOTE: rst gates the write strobe combinationally so a reset mid-burst stops writes at once.
  assign mem_we    = !rst && (in_burst ? we_q : (pl_req && pl_we));

  assign pl_rdata  = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected transfers from a reference
// model; a negedge monitor pops and compares whenever the DUT transfers.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_req, pl_we, pl_stall;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_wdata, pl_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_beat, dma_done;
  logic [AW-1:0] dma_addr;
  logic [LW-1:0] dma_len;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DW(DW), .AW(AW), .LW(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .pl_req(pl_req), .pl_we(pl_we), .pl_addr(pl_addr), .pl_wdata(pl_wdata),
    .pl_rdata(pl_rdata), .pl_stall(pl_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 7) ^ 16'hA5C3;
  endfunction

  // Data memory attached to the port: combinational read, write on the edge.
  logic [DW-1:0] dev_mem [2**AW];
  logic          mem_init;
  assign mem_rdata = dev_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2**AW; i++) dev_mem[i] <= pat(i);
    end else if (mem_we) begin
      dev_mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    logic          done;
    logic          stall;
  } ev_t;

  ev_t dma_q[$];
  ev_t pl_q[$];

  // Reference model: remaining burst beats, consecutive denied DMA cycles, shadow memory.
  logic [DW-1:0] ref_mem [2**AW];
  int            m_left, m_wait, cur_cyc, dw_seq;
  logic [AW-1:0] m_addr;
  logic          m_we;
  bit            dma_hold;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cur_cyc);
    end
  endtask

  task automatic model_step(output bit granted);
    ev_t e;
    granted = 1'b0;
    cur_cyc++;
    if (rst) begin
      m_left = 0;
      m_wait = 0;
      return;
    end
    if (m_left > 0) begin
      e.cyc   = cur_cyc;
      e.addr  = m_addr;
      e.we    = m_we;
      e.data  = m_we ? dma_wdata : ref_mem[m_addr];
      e.done  = (m_left == 1);
      e.stall = pl_req;
      if (m_we) ref_mem[m_addr] = dma_wdata;
      dma_q.push_back(e);
      m_addr = m_addr + AW'(1);
      m_left--;
    end else begin
      if (pl_req) begin
        e.cyc   = cur_cyc;
        e.addr  = pl_addr;
        e.we    = pl_we;
        e.data  = pl_we ? pl_wdata : ref_mem[pl_addr];
        e.done  = 1'b0;
        e.stall = 1'b0;
        if (pl_we) ref_mem[pl_addr] = pl_wdata;
        pl_q.push_back(e);
      end
      if (!dma_req) begin
        m_wait = 0;
      end else if (!pl_req || m_wait >= SL) begin
        m_left  = int'(dma_len) + 1;
        m_addr  = dma_addr;
        m_we    = dma_we;
        m_wait  = 0;
        granted = 1'b1;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic tick();
    bit granted;
    if (m_left > 0) begin
      dma_wdata = DW'(dw_seq);
      dw_seq++;
    end else begin
      dma_wdata = DW'($urandom);
    end
    model_step(granted);
    @(posedge clk);
    #1;
    if (granted && !dma_hold) dma_req = 1'b0;
  endtask

  task automatic pl(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_req   = req;
    pl_we    = we;
    pl_addr  = a;
    pl_wdata = d;
  endtask

  task automatic dma_set(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    dma_req  = 1'b1;
    dma_addr = a;
    dma_len  = l;
    dma_we   = w;
  endtask

  task automatic run_dma();
    for (int i = 0; i < 100 && (dma_req || m_left > 0); i++) tick();
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_gnt", 32'(dma_gnt), 0);
      check("rst_done", 32'(dma_done), 0);
      check("rst_stall", 32'(pl_stall), 0);
    end else begin
      if (dma_beat) begin
        if (dma_q.size() == 0) begin
          check("dma_beat_expected", 32'(dma_q.size()), 1);
        end else begin
          e = dma_q.pop_front();
          check("dma_cycle", 32'(cur_cyc), 32'(e.cyc));
          check("dma_gnt", 32'(dma_gnt), 1);
          check("dma_addr", 32'(mem_addr), 32'(e.addr));
          check("dma_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("dma_wdata", 32'(mem_wdata), 32'(e.data));
          else      check("dma_rdata", 32'(dma_rdata), 32'(e.data));
          check("dma_done", 32'(dma_done), 32'(e.done));
          check("pl_stall", 32'(pl_stall), 32'(e.stall));
        end
      end else begin
        check("idle_gnt", 32'(dma_gnt), 0);
        check("idle_done", 32'(dma_done), 0);
        if (!pl_req) check("idle_mem_we", 32'(mem_we), 0);
      end
      if (pl_req && !pl_stall) begin
        if (pl_q.size() == 0) begin
          check("pl_access_expected", 32'(pl_q.size()), 1);
        end else begin
          e = pl_q.pop_front();
          check("pl_cycle", 32'(cur_cyc), 32'(e.cyc));
          check("pl_addr", 32'(mem_addr), 32'(e.addr));
          check("pl_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("pl_wdata", 32'(mem_wdata), 32'(e.data));
          else      check("pl_rdata", 32'(pl_rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int bad;
    int first_bad;
    rst      = 1'b1;
    mem_init = 1'b1;
    m_left   = 0;
    m_wait   = 0;
    cur_cyc  = 0;
    dw_seq   = 1;
    dma_hold = 1'b0;
    m_addr   = '0;
    m_we     = 1'b0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = pat(i);
    pl(1'b1, 1'b1, 16'h0010, 16'h1234);
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    tick();
    mem_init = 1'b0;
    tick();
    rst = 1'b0;
    pl(1'b0, 1'b0, '0, '0);
    tick();

    // Pipeline only: store then load back.
    pl(1'b1, 1'b1, 16'h0010, 16'hBEEF); tick();
    pl(1'b1, 1'b0, 16'h0010, 16'h0000); tick();
    pl(1'b0, 1'b0, '0, '0);             tick();

    // DMA write, pipeline idle, data 1..4.
    dw_seq = 1;
    dma_set(16'h0100, LW'(3), 1'b1);
    run_dma();
    tick();

    // Starvation: pipeline loads every cycle while DMA waits.
    pl(1'b1, 1'b0, 16'h0020, '0);
    dma_set(16'h0300, LW'(2), 1'b1);
    run_dma();
    pl(1'b0, 1'b0, '0, '0);
    tick();

    // Address wrap on a read burst, then a maximum-length write burst.
    dma_set(16'hFFFE, LW'(3), 1'b0);
    run_dma();
    dma_set(16'h4000, LW'(15), 1'b1);
    run_dma();
    tick();

    // Reset during the second beat of a len-7 write burst at 0x0000.
    dma_set(16'h0000, LW'(7), 1'b1);
    tick();
    tick();
    rst = 1'b1;
    pl(1'b1, 1'b1, 16'h0050, 16'h7777);
    tick();
    rst = 1'b0;
    pl(1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Back-to-back: request held through done, one pipeline store in the gap.
    dma_hold = 1'b1;
    dma_set(16'h0500, LW'(1), 1'b1);
    tick();
    pl(1'b1, 1'b0, 16'h0010, '0);
    for (int i = 0; i < 50 && m_left > 0; i++) tick();
    pl(1'b1, 1'b1, 16'h0600, 16'hCAFE);
    tick();
    pl(1'b0, 1'b0, '0, '0);
    dma_hold = 1'b0;
    dma_addr = 16'h0510;
    run_dma();
    tick();

    // Randomized mixed traffic.
    for (int n = 0; n < 800; n++) begin
      pl($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), {8'h00, 8'($urandom)}, DW'($urandom));
      if (!dma_req && m_left == 0 && $urandom_range(0, 7) == 0) begin
        dma_set(($urandom_range(0, 3) == 0) ? (16'hFFF0 | AW'($urandom_range(0, 15)))
                                            : {8'h00, 8'($urandom)},
                LW'($urandom), 1'($urandom_range(0, 1)));
      end
      tick();
    end
    pl(1'b0, 1'b0, '0, '0);
    run_dma();
    for (int i = 0; i < 3; i++) tick();

    check("dma_q_empty", 32'(dma_q.size()), 0);
    check("pl_q_empty", 32'(pl_q.size()), 0);
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 2**AW; i++) begin
      if (dev_mem[i] !== ref_mem[i]) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    if (bad != 0) $display("first differing word at 0x%0h", first_bad);
    check("mem_contents_diffs", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
